// File: rtl/life_step.sv
// life_step: computes one Conway's Game of Life generation (B3/S23) over a
// board held in an external single-port RAM, one row per word, rewriting
// every row in place. The RAM is read one cycle ahead of use and the board
// is walked top to bottom with a three-row window of pre-step data.
module life_step #(
    parameter int ROWS = 31,
    parameter int COLS = 40
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [15:0]     gen,
    output logic [4:0]      ram_addr,
    input  logic [COLS-1:0] ram_q,
    output logic [COLS-1:0] ram_data,
    output logic            ram_wren
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] PRIME_RD  = 3'd1;
    localparam logic [2:0] PRIME_CAP = 3'd2;
    localparam logic [2:0] ROW_RD    = 3'd3;
    localparam logic [2:0] ROW_CAP   = 3'd4;
    localparam logic [2:0] ROW_WR    = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;

    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    logic [2:0]      state;
    logic [4:0]      row;
    logic [COLS-1:0] prev_row;
    logic [COLS-1:0] cur_row;
    logic [COLS-1:0] nxt_row;
    logic [COLS-1:0] next_gen_row;
    logic            is_last_row;

    logic [COLS+1:0] prev_pad;
    logic [COLS+1:0] cur_pad;
    logic [COLS+1:0] nxt_pad;
    logic [3:0]      count;

    assign is_last_row = (row == LAST_ROW);

    // Sequencer: walks the rows keeping original (pre-step) data in the
    // prev/cur/nxt window so in-place writes never feed back as neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            row      <= '0;
            prev_row <= '0;
            cur_row  <= '0;
            nxt_row  <= '0;
            gen      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= PRIME_RD;
                        row      <= '0;
                        prev_row <= '0;
                    end
                end
                PRIME_RD: begin
                    state <= PRIME_CAP;
                end
                PRIME_CAP: begin
                    cur_row <= ram_q;
                    state   <= ROW_RD;
                end
                ROW_RD: begin
                    state <= ROW_CAP;
                end
                ROW_CAP: begin
                    nxt_row <= is_last_row ? '0 : ram_q;
                    state   <= ROW_WR;
                end
                ROW_WR: begin
                    prev_row <= cur_row;
                    cur_row  <= nxt_row;
                    if (is_last_row) begin
                        state <= DONE;
                    end else begin
                        row   <= row + 5'd1;
                        state <= ROW_RD;
                    end
                end
                DONE: begin
                    gen   <= gen + 16'd1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Next-generation rule for the current row: dead padding on both sides
    // makes columns beyond the board edge count as dead neighbours.
    always_comb begin
        prev_pad     = {1'b0, prev_row, 1'b0};
        cur_pad      = {1'b0, cur_row, 1'b0};
        nxt_pad      = {1'b0, nxt_row, 1'b0};
        count        = '0;
        next_gen_row = '0;
        for (int i = 0; i < COLS; i++) begin
            count = {3'b000, prev_pad[i]} + {3'b000, prev_pad[i+1]} +
                    {3'b000, prev_pad[i+2]} +
                    {3'b000, cur_pad[i]}  + {3'b000, cur_pad[i+2]} +
                    {3'b000, nxt_pad[i]}  + {3'b000, nxt_pad[i+1]} +
                    {3'b000, nxt_pad[i+2]};
            next_gen_row[i] = (count == 4'd3) || ((count == 4'd2) && cur_row[i]);
        end
    end

    // RAM port and status decode; the read address for the row below the
    // last one is held at 0 because that row is dead padding and the word
    // past the board must never be touched.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        ram_addr = '0;
        ram_data = '0;
        ram_wren = 1'b0;
        case (state)
            PRIME_RD, PRIME_CAP: begin
                busy     = 1'b1;
                ram_addr = '0;
            end
            ROW_RD, ROW_CAP: begin
                busy     = 1'b1;
                ram_addr = is_last_row ? 5'd0 : row + 5'd1;
            end
            ROW_WR: begin
                busy     = 1'b1;
                ram_addr = row;
                ram_wren = 1'b1;
                ram_data = next_gen_row;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_life_step.sv
// tb_life_step: directed scenarios for life_step against a behavioural
// board RAM, with hand-computed expected boards, latencies and counts.
module tb_life_step;

    localparam int ROWS = 31;
    localparam int COLS = 40;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            busy;
    logic            done;
    logic [15:0]     gen;
    logic [4:0]      ram_addr;
    logic [COLS-1:0] ram_q;
    logic [COLS-1:0] ram_data;
    logic            ram_wren;

    int total = 0;
    int bad   = 0;

    logic [COLS-1:0] mem  [0:31];
    logic [COLS-1:0] expv [0:31];

    int wr_count  = 0;
    int oob_count = 0;
    int order_err = 0;
    int exp_row   = 0;

    life_step #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .gen      (gen),
        .ram_addr (ram_addr),
        .ram_q    (ram_q),
        .ram_data (ram_data),
        .ram_wren (ram_wren)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Board RAM with one-cycle read latency, plus write bookkeeping
    always @(posedge clk) begin
        ram_q <= mem[ram_addr];
        if (ram_addr >= 5'd31) oob_count++;
        if (ram_wren) begin
            if (int'(ram_addr) != exp_row) order_err++;
            exp_row++;
            mem[ram_addr] = ram_data;
            wr_count++;
        end else if (!busy) begin
            exp_row = 0;
        end
    end

    task automatic clear_board();
        for (int i = 0; i < 32; i++) begin
            mem[i]  = '0;
            expv[i] = '0;
        end
    endtask

    // One step; lat = edges from the start-sampling edge to the edge that
    // captures done=1, or -1 on timeout
    task automatic run_step(output int lat, output logic busy_first);
        lat = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        busy_first = busy;
        for (int n = 0; n < 300; n++) begin
            if (done) begin
                lat = n + 1;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        total++; if (done !== 1'b0)      begin bad++; $display("[TB] FAIL reset_done got %b want 0", done); end
        total++; if (ram_wren !== 1'b0)  begin bad++; $display("[TB] FAIL reset_wren got %b want 0", ram_wren); end
        total++; if (ram_addr !== 5'd0)  begin bad++; $display("[TB] FAIL reset_addr got %0d want 0", ram_addr); end
        total++; if (ram_data !== '0)    begin bad++; $display("[TB] FAIL reset_data got %h want 0", ram_data); end
        total++; if (gen !== 16'd0)      begin bad++; $display("[TB] FAIL reset_gen got %0d want 0", gen); end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_priority busy got %b want 0", busy); end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_blinker();
        int lat; logic bf; int w0;
        clear_board();
        mem[14] = 40'h00_0008_0000;
        mem[15] = 40'h00_0008_0000;
        mem[16] = 40'h00_0008_0000;
        expv[15] = 40'h00_001C_0000;
        w0 = wr_count;
        run_step(lat, bf);
        total++; if (lat != 96)       begin bad++; $display("[TB] FAIL blinker_latency got %0d want 96", lat); end
        total++; if (bf !== 1'b1)     begin bad++; $display("[TB] FAIL blinker_busy got %b want 1", bf); end
        total++; if (gen !== 16'd1)   begin bad++; $display("[TB] FAIL blinker_gen got %0d want 1", gen); end
        total++; if (busy !== 1'b0)   begin bad++; $display("[TB] FAIL blinker_idle_busy got %b want 0", busy); end
        total++; if (wr_count - w0 != 31) begin bad++; $display("[TB] FAIL blinker_writes got %0d want 31", wr_count - w0); end
        for (int r = 0; r < ROWS; r++) begin
            total++;
            if (mem[r] !== expv[r]) begin
                bad++; $display("[TB] FAIL blinker_row%0d got %h want %h", r, mem[r], expv[r]);
            end
        end
    endtask

    task automatic test_block();
        int lat; logic bf; int w0;
        clear_board();
        mem[10]  = 40'h06_0000_0000;
        mem[11]  = 40'h06_0000_0000;
        expv[10] = 40'h06_0000_0000;
        expv[11] = 40'h06_0000_0000;
        w0 = wr_count;
        run_step(lat, bf);
        total++; if (lat != 96)           begin bad++; $display("[TB] FAIL block_latency got %0d want 96", lat); end
        total++; if (wr_count - w0 != 31) begin bad++; $display("[TB] FAIL block_writes got %0d want 31", wr_count - w0); end
        total++; if (gen !== 16'd2)       begin bad++; $display("[TB] FAIL block_gen got %0d want 2", gen); end
        for (int r = 0; r < ROWS; r++) begin
            total++;
            if (mem[r] !== expv[r]) begin
                bad++; $display("[TB] FAIL block_row%0d got %h want %h", r, mem[r], expv[r]);
            end
        end
    endtask

    task automatic test_glider();
        int lat; logic bf;
        clear_board();
        mem[0]  = 40'h80_0000_0000;
        mem[1]  = 40'h60_0000_0000;
        mem[2]  = 40'hC0_0000_0000;
        expv[0] = 40'h40_0000_0000;
        expv[1] = 40'h20_0000_0000;
        expv[2] = 40'hE0_0000_0000;
        run_step(lat, bf);
        total++; if (lat != 96)         begin bad++; $display("[TB] FAIL glider_latency got %0d want 96", lat); end
        total++; if (gen !== 16'd3)     begin bad++; $display("[TB] FAIL glider_gen got %0d want 3", gen); end
        for (int r = 0; r < ROWS; r++) begin
            total++;
            if (mem[r] !== expv[r]) begin
                bad++; $display("[TB] FAIL glider_row%0d got %h want %h", r, mem[r], expv[r]);
            end
        end
    endtask

    task automatic test_edge();
        int lat; logic bf;
        clear_board();
        mem[30]  = 40'h00_0000_0007;
        mem[31]  = 40'hFF_FFFF_FFFF;
        expv[29] = 40'h00_0000_0002;
        expv[30] = 40'h00_0000_0002;
        run_step(lat, bf);
        total++; if (gen !== 16'd4)     begin bad++; $display("[TB] FAIL edge_gen got %0d want 4", gen); end
        total++; if (oob_count != 0)    begin bad++; $display("[TB] FAIL edge_word31_access got %0d want 0", oob_count); end
        total++; if (order_err != 0)    begin bad++; $display("[TB] FAIL edge_write_order got %0d want 0", order_err); end
        total++; if (mem[31] !== 40'hFF_FFFF_FFFF) begin bad++; $display("[TB] FAIL edge_word31 got %h want ffffffffff", mem[31]); end
        for (int r = 0; r < ROWS; r++) begin
            total++;
            if (mem[r] !== expv[r]) begin
                bad++; $display("[TB] FAIL edge_row%0d got %h want %h", r, mem[r], expv[r]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int pulses; logic [15:0] g0;
        clear_board();
        g0 = gen;
        pulses = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        total++; if (pulses != 1)       begin bad++; $display("[TB] FAIL ignored_start_pulses got %0d want 1", pulses); end
        total++; if (gen !== g0 + 16'd1) begin bad++; $display("[TB] FAIL ignored_start_gen got %0d want %0d", gen, g0 + 16'd1); end
    endtask

    task automatic test_back_to_back();
        int pulses; int pos [0:2];
        clear_board();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        pos[0] = 0; pos[1] = 0; pos[2] = 0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int n = 0; n < 400; n++) begin
            if (done) begin
                if (pulses < 3) pos[pulses] = n;
                pulses++;
                if (pulses == 3) start = 1'b0;
            end
            if (pulses >= 3) break;
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (pulses != 3)           begin bad++; $display("[TB] FAIL b2b_pulses got %0d want 3", pulses); end
        total++; if (pos[1] - pos[0] != 97) begin bad++; $display("[TB] FAIL b2b_spacing1 got %0d want 97", pos[1] - pos[0]); end
        total++; if (pos[2] - pos[1] != 97) begin bad++; $display("[TB] FAIL b2b_spacing2 got %0d want 97", pos[2] - pos[1]); end
        total++; if (gen !== 16'd3)         begin bad++; $display("[TB] FAIL b2b_gen got %0d want 3", gen); end
        total++; if (busy !== 1'b0)         begin bad++; $display("[TB] FAIL b2b_stopped busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int w0;
        clear_board();
        mem[14] = 40'h00_0008_0000;
        mem[15] = 40'h00_0008_0000;
        mem[16] = 40'h00_0008_0000;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (38) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++; if (busy !== 1'b0)     begin bad++; $display("[TB] FAIL midreset_busy got %b want 0", busy); end
        total++; if (ram_wren !== 1'b0) begin bad++; $display("[TB] FAIL midreset_wren got %b want 0", ram_wren); end
        total++; if (gen !== 16'd0)     begin bad++; $display("[TB] FAIL midreset_gen got %0d want 0", gen); end
        @(negedge clk);
        reset = 1'b0;
        w0 = wr_count;
        repeat (200) @(negedge clk);
        total++; if (wr_count != w0)    begin bad++; $display("[TB] FAIL midreset_writes got %0d want 0", wr_count - w0); end
        total++; if (mem[15] !== 40'h00_0008_0000) begin bad++; $display("[TB] FAIL midreset_row15 got %h want 0000080000", mem[15]); end
        total++; if (busy !== 1'b0)     begin bad++; $display("[TB] FAIL midreset_idle busy got %b want 0", busy); end
    endtask

    // Scenario sequence
    initial begin
        reset = 1'b1;
        start = 1'b0;
        clear_board();
        test_reset();
        test_blinker();
        test_block();
        test_glider();
        test_edge();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
